// File: rtl/avmm_pipe_bridge.sv
// avmm_pipe_bridge
//   Pipelined Avalon-MM bridge. Commands accepted on the agent side are
//   buffered in a small FIFO and replayed in order on the host side. Host
//   reads are tracked so that no more than MAX_PENDING are outstanding, and
//   read responses are registered back to the agent side one clock later.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_*               : agent side (address, byteenable, read, write,
//                       writedata in; readdata, waitrequest, readdatavalid out)
//   m_*               : host side (address, byteenable, read, write,
//                       writedata out; readdata, waitrequest, readdatavalid in)
//   cmd_level         : number of buffered commands
//   pending           : number of outstanding host reads
//   err               : sticky; bit0 = read and write together,
//                       bit1 = response with no read outstanding
//
// Handshake: a command transfers on a rising edge where (read | write) is
// high and waitrequest is low; readdatavalid responses have no backpressure.
module avmm_pipe_bridge #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int CMD_DEPTH   = 4,
   parameter int MAX_PENDING = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [ADDR_W-1:0]              s_address,
   input  logic [DATA_W/8-1:0]            s_byteenable,
   input  logic                           s_read,
   input  logic                           s_write,
   input  logic [DATA_W-1:0]              s_writedata,
   output logic [DATA_W-1:0]              s_readdata,
   output logic                           s_waitrequest,
   output logic                           s_readdatavalid,
   output logic [ADDR_W-1:0]              m_address,
   output logic [DATA_W/8-1:0]            m_byteenable,
   output logic                           m_read,
   output logic                           m_write,
   output logic [DATA_W-1:0]              m_writedata,
   input  logic [DATA_W-1:0]              m_readdata,
   input  logic                           m_waitrequest,
   input  logic                           m_readdatavalid,
   output logic [$clog2(CMD_DEPTH):0]     cmd_level,
   output logic [$clog2(MAX_PENDING):0]   pending,
   output logic [1:0]                     err
);

   localparam int BE_W  = DATA_W / 8;
   localparam int PTR_W = $clog2(CMD_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int PND_W = $clog2(MAX_PENDING) + 1;
   localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(CMD_DEPTH);
   localparam logic [PND_W-1:0] MAXP_L  = PND_W'(MAX_PENDING);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [BE_W-1:0]   be;
      logic              wr;
      logic [DATA_W-1:0] data;
   } cmd_t;

   cmd_t              mem_q [CMD_DEPTH];
   cmd_t              mem_d [CMD_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [PND_W-1:0]  pending_q, pending_d;
   logic [1:0]        err_q, err_d;
   logic              sdv_q, sdv_d;
   logic [DATA_W-1:0] srd_q, srd_d;

   cmd_t head;
   logic head_valid;
   logic push, pop, read_pop, resp_ok;

   assign head       = mem_q[rd_ptr_q];
   assign head_valid = (level_q != '0);

   // Host side is driven purely from registered FIFO state, so nothing on
   // the agent side can reach it combinationally. Fields are zeroed while
   // the FIFO is empty, which also covers the reset values.
   assign m_write      = head_valid & head.wr;
   assign m_read       = head_valid & ~head.wr & (pending_q < MAXP_L);
   assign m_address    = head_valid ? head.addr : '0;
   assign m_byteenable = head_valid ? head.be   : '0;
   assign m_writedata  = head_valid ? head.data : '0;

   assign s_waitrequest   = (level_q == DEPTH_L) | ~rst_n;
   assign s_readdatavalid = sdv_q;
   assign s_readdata      = srd_q;
   assign cmd_level       = level_q;
   assign pending         = pending_q;
   assign err             = err_q;

   assign push     = (s_read | s_write) & ~s_waitrequest;
   assign pop      = (m_read | m_write) & ~m_waitrequest;
   assign read_pop = m_read & ~m_waitrequest;
   assign resp_ok  = m_readdatavalid & (pending_q != '0);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         // A simultaneous read/write request is kept as a write.
         mem_d[wr_ptr_q] = '{addr: s_address, be: s_byteenable, wr: s_write, data: s_writedata};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      pending_d = pending_q;
      case ({read_pop, resp_ok})
         2'b10:   pending_d = pending_q + 1'b1;
         2'b01:   pending_d = pending_q - 1'b1;
         default: pending_d = pending_q;
      endcase
      // A response with nothing outstanding is dropped and flagged.
      err_d = err_q | {m_readdatavalid & (pending_q == '0), push & s_read & s_write};
      sdv_d = resp_ok;
      srd_d = resp_ok ? m_readdata : srd_q;
   end

   // Payload storage needs no reset: it is only visible through a valid head.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         pending_q <= '0;
         err_q     <= '0;
         sdv_q     <= 1'b0;
         srd_q     <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         pending_q <= pending_d;
         err_q     <= err_d;
         sdv_q     <= sdv_d;
         srd_q     <= srd_d;
      end
   end

endmodule

// File: tb/tb_avmm_pipe_bridge.sv
// tb_avmm_pipe_bridge
//   Self-checking bench for avmm_pipe_bridge with default parameters.
//   Directed scenarios followed by a randomized run checked against a
//   queue-based model of the bridge.
module tb_avmm_pipe_bridge;

   localparam int ADDR_W      = 32;
   localparam int DATA_W      = 32;
   localparam int BE_W        = DATA_W / 8;
   localparam int CMD_DEPTH   = 4;
   localparam int MAX_PENDING = 4;
   localparam int LVL_W       = $clog2(CMD_DEPTH) + 1;
   localparam int PND_W       = $clog2(MAX_PENDING) + 1;
   localparam int CMD_W       = ADDR_W + BE_W + 1 + DATA_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [ADDR_W-1:0] s_address = '0;
   logic [BE_W-1:0]   s_byteenable = '0;
   logic              s_read = 1'b0;
   logic              s_write = 1'b0;
   logic [DATA_W-1:0] s_writedata = '0;
   logic [DATA_W-1:0] s_readdata;
   logic              s_waitrequest;
   logic              s_readdatavalid;
   logic [ADDR_W-1:0] m_address;
   logic [BE_W-1:0]   m_byteenable;
   logic              m_read;
   logic              m_write;
   logic [DATA_W-1:0] m_writedata;
   logic [DATA_W-1:0] m_readdata = '0;
   logic              m_waitrequest = 1'b0;
   logic              m_readdatavalid = 1'b0;
   logic [LVL_W-1:0]  cmd_level;
   logic [PND_W-1:0]  pending;
   logic [1:0]        err;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected host-side command order: {addr, be, write flag, data}.
   logic [CMD_W-1:0] exp_q[$];

   avmm_pipe_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_DEPTH(CMD_DEPTH), .MAX_PENDING(MAX_PENDING)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
      .s_write(s_write), .s_writedata(s_writedata), .s_readdata(s_readdata),
      .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid),
      .m_address(m_address), .m_byteenable(m_byteenable), .m_read(m_read),
      .m_write(m_write), .m_writedata(m_writedata), .m_readdata(m_readdata),
      .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid),
      .cmd_level(cmd_level), .pending(pending), .err(err)
   );

   // Clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      s_read = 1'b0; s_write = 1'b0; m_readdatavalid = 1'b0; m_waitrequest = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (s_waitrequest !== 1'b1) begin n_fail++; $display("FAIL reset_waitreq got=%0b exp=1", s_waitrequest); end
      n_checks++; if (cmd_level !== '0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", cmd_level); end
      n_checks++; if (pending !== '0) begin n_fail++; $display("FAIL reset_pending got=%0d exp=0", pending); end
      n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL reset_err got=%b exp=00", err); end
      n_checks++; if ({m_read, m_write, s_readdatavalid} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes got=%b exp=000", {m_read, m_write, s_readdatavalid}); end
      n_checks++; if ({m_address, m_byteenable, m_writedata, s_readdata} !== '0) begin n_fail++; $display("FAIL reset_fields got=%h/%h/%h/%h exp=0", m_address, m_byteenable, m_writedata, s_readdata); end
      rst_n = 1'b1;
      #1;
      n_checks++; if (s_waitrequest !== 1'b0) begin n_fail++; $display("FAIL release_waitreq got=%0b exp=0", s_waitrequest); end
   endtask

   // Runs straight after reset release: the first edge must accept.
   task automatic test_single_write();
      s_write = 1'b1; s_address = 32'h10; s_byteenable = 4'hF; s_writedata = 32'hDEADBEEF;
      m_waitrequest = 1'b0;
      n_checks++; if (m_write !== 1'b0) begin n_fail++; $display("FAIL wr_no_comb_path got=%0b exp=0", m_write); end
      tick();
      s_write = 1'b0; s_address = '0; s_writedata = '0;
      n_checks++; if ({m_write, m_read} !== 2'b10) begin n_fail++; $display("FAIL wr_strobe got=%b exp=10", {m_write, m_read}); end
      n_checks++; if ({m_address, m_byteenable, m_writedata} !== {32'h10, 4'hF, 32'hDEADBEEF}) begin n_fail++; $display("FAIL wr_fields got=%h/%h/%h exp=10/f/deadbeef", m_address, m_byteenable, m_writedata); end
      n_checks++; if (cmd_level !== 3'd1) begin n_fail++; $display("FAIL wr_level1 got=%0d exp=1", cmd_level); end
      tick();
      n_checks++; if (m_write !== 1'b0) begin n_fail++; $display("FAIL wr_one_cycle got=%0b exp=0", m_write); end
      n_checks++; if (cmd_level !== 3'd0) begin n_fail++; $display("FAIL wr_level0 got=%0d exp=0", cmd_level); end
   endtask

   task automatic test_backpressure();
      int sent;
      logic [CMD_W-1:0] head;
      sent = 0;
      exp_q.delete();
      m_waitrequest = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (sent < CMD_DEPTH + 1) begin
            s_write = 1'b1; s_address = 32'h100 + sent; s_byteenable = 4'(sent + 1); s_writedata = $urandom;
         end else begin
            s_write = 1'b0;
         end
         if (cyc == 6) begin
            n_checks++; if (s_waitrequest !== 1'b1) begin n_fail++; $display("FAIL bp_full_waitreq got=%0b exp=1", s_waitrequest); end
            n_checks++; if (cmd_level !== 3'd4) begin n_fail++; $display("FAIL bp_full_level got=%0d exp=4", cmd_level); end
         end
         if (cyc == 8) m_waitrequest = 1'b0;
         if (m_write && !m_waitrequest) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL bp_extra_cmd got=%h exp=none", m_address);
            end else begin
               head = exp_q.pop_front();
               if ({m_address, m_byteenable, 1'b1, m_writedata} !== head) begin
                  n_fail++; $display("FAIL bp_order got=%h/%h/%h exp=%h", m_address, m_byteenable, m_writedata, head);
               end
            end
         end
         if (s_write && !s_waitrequest) begin
            exp_q.push_back({s_address, s_byteenable, 1'b1, s_writedata});
            sent++;
         end
         tick();
      end
      s_write = 1'b0;
      n_checks++; if (sent != CMD_DEPTH + 1) begin n_fail++; $display("FAIL bp_accepted got=%0d exp=5", sent); end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drained got=%0d left exp=0", exp_q.size()); end
      n_checks++; if (cmd_level !== 3'd0) begin n_fail++; $display("FAIL bp_level got=%0d exp=0", cmd_level); end
   endtask

   task automatic test_read_limit();
      logic [DATA_W-1:0] d;
      m_waitrequest = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_read = 1'b1; s_address = 32'h200 + i; s_byteenable = 4'hF;
         tick();
      end
      s_read = 1'b0;
      tick(); tick();
      n_checks++; if (pending !== 3'd4) begin n_fail++; $display("FAIL rl_pending4 got=%0d exp=4", pending); end
      n_checks++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL rl_stall got=%0b exp=0", m_read); end
      n_checks++; if (cmd_level !== 3'd1) begin n_fail++; $display("FAIL rl_level got=%0d exp=1", cmd_level); end
      m_readdata = 32'h1234; m_readdatavalid = 1'b1;
      tick();
      m_readdatavalid = 1'b0;
      n_checks++; if ({s_readdatavalid, s_readdata} !== {1'b1, 32'h1234}) begin n_fail++; $display("FAIL rl_resp got=%0b/%h exp=1/1234", s_readdatavalid, s_readdata); end
      n_checks++; if ({m_read, m_address} !== {1'b1, 32'h204}) begin n_fail++; $display("FAIL rl_fifth got=%0b/%h exp=1/204", m_read, m_address); end
      tick();
      n_checks++; if (s_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rl_pulse got=%0b exp=0", s_readdatavalid); end
      n_checks++; if (pending !== 3'd4) begin n_fail++; $display("FAIL rl_refill got=%0d exp=4", pending); end
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         m_readdata = d; m_readdatavalid = 1'b1;
         tick();
         n_checks++; if ({s_readdatavalid, s_readdata} !== {1'b1, d}) begin n_fail++; $display("FAIL rl_b2b got=%0b/%h exp=1/%h", s_readdatavalid, s_readdata, d); end
      end
      m_readdatavalid = 1'b0;
      tick();
      n_checks++; if ({s_readdatavalid, pending} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL rl_done got=%0b/%0d exp=0/0", s_readdatavalid, pending); end
   endtask

   task automatic test_simultaneous();
      logic [DATA_W-1:0] d;
      s_read = 1'b1; s_address = 32'h300;
      tick();
      s_read = 1'b0;
      tick();
      n_checks++; if (pending !== 3'd1) begin n_fail++; $display("FAIL sim_pending1 got=%0d exp=1", pending); end
      s_read = 1'b1; s_address = 32'h304;
      tick();
      s_read = 1'b0;
      d = $urandom;
      m_readdata = d; m_readdatavalid = 1'b1;
      tick();
      m_readdatavalid = 1'b0;
      n_checks++; if (pending !== 3'd1) begin n_fail++; $display("FAIL sim_pending_same got=%0d exp=1", pending); end
      n_checks++; if ({s_readdatavalid, s_readdata} !== {1'b1, d}) begin n_fail++; $display("FAIL sim_resp got=%0b/%h exp=1/%h", s_readdatavalid, s_readdata, d); end
      m_readdatavalid = 1'b1;
      tick();
      m_readdatavalid = 1'b0;
      n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL sim_pending0 got=%0d exp=0", pending); end
   endtask

   task automatic test_errors();
      m_readdata = 32'hBAD; m_readdatavalid = 1'b1;
      tick();
      m_readdatavalid = 1'b0;
      n_checks++; if (s_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL err_dropped got=%0b exp=0", s_readdatavalid); end
      n_checks++; if (err !== 2'b10) begin n_fail++; $display("FAIL err_unexp got=%b exp=10", err); end
      s_read = 1'b1; s_write = 1'b1; s_address = 32'h30; s_byteenable = 4'h3; s_writedata = 32'hCAFEF00D;
      tick();
      s_read = 1'b0; s_write = 1'b0;
      n_checks++; if ({m_write, m_read, m_writedata} !== {2'b10, 32'hCAFEF00D}) begin n_fail++; $display("FAIL err_rw_as_write got=%b/%h exp=10/cafef00d", {m_write, m_read}, m_writedata); end
      n_checks++; if (err !== 2'b11) begin n_fail++; $display("FAIL err_both got=%b exp=11", err); end
      tick();
      n_checks++; if (cmd_level !== 3'd0) begin n_fail++; $display("FAIL err_level got=%0d exp=0", cmd_level); end
   endtask

   task automatic test_reset_mid();
      m_waitrequest = 1'b0;
      s_read = 1'b1; s_address = 32'h400;
      tick(); tick();
      s_read = 1'b0;
      tick();
      m_waitrequest = 1'b1;
      s_write = 1'b1; s_writedata = 32'h55AA55AA;
      tick(); tick(); tick();
      s_write = 1'b0;
      n_checks++; if ({cmd_level, pending} !== {3'd3, 3'd2}) begin n_fail++; $display("FAIL mid_setup got=%0d/%0d exp=3/2", cmd_level, pending); end
      rst_n = 1'b0;
      #1;
      n_checks++; if ({cmd_level, pending, err} !== '0) begin n_fail++; $display("FAIL mid_status got=%0d/%0d/%b exp=0/0/00", cmd_level, pending, err); end
      n_checks++; if ({m_read, m_write, s_readdatavalid, s_waitrequest} !== 4'b0001) begin n_fail++; $display("FAIL mid_strobes got=%b exp=0001", {m_read, m_write, s_readdatavalid, s_waitrequest}); end
      n_checks++; if ({m_address, m_byteenable, m_writedata, s_readdata} !== '0) begin n_fail++; $display("FAIL mid_fields got=%h/%h/%h/%h exp=0", m_address, m_byteenable, m_writedata, s_readdata); end
      tick();
      rst_n = 1'b1;
      m_waitrequest = 1'b0;
      m_readdata = $urandom; m_readdatavalid = 1'b1;
      tick();
      m_readdatavalid = 1'b0;
      n_checks++; if ({err, s_readdatavalid, pending} !== {2'b10, 1'b0, 3'd0}) begin n_fail++; $display("FAIL mid_late_resp got=%b/%0b/%0d exp=10/0/0", err, s_readdatavalid, pending); end
   endtask

   // Randomized traffic against a queue model of the bridge.
   task automatic test_random();
      int model_pend;
      int r;
      logic [CMD_W-1:0] head;
      logic [DATA_W-1:0] resp_data;
      bit e_wr, e_rd, pop, push, resp;
      model_pend = 0;
      exp_q.delete();
      head = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         r = $urandom_range(0, 3);
         s_read = (r == 1);
         s_write = (r == 2);
         s_address = $urandom; s_byteenable = 4'($urandom); s_writedata = $urandom;
         m_waitrequest = ($urandom_range(0, 3) == 0);
         m_readdatavalid = (model_pend > 0) && ($urandom_range(0, 2) == 0);
         m_readdata = $urandom;
         e_wr = 1'b0; e_rd = 1'b0;
         if (exp_q.size() > 0) begin
            head = exp_q[0];
            e_wr = head[DATA_W];
            e_rd = !head[DATA_W] && (model_pend < MAX_PENDING);
         end
         n_checks++; if (s_waitrequest !== (exp_q.size() == CMD_DEPTH)) begin n_fail++; $display("FAIL rnd_waitreq cyc=%0d got=%0b exp=%0b", cyc, s_waitrequest, exp_q.size() == CMD_DEPTH); end
         n_checks++; if ({m_read, m_write} !== {e_rd, e_wr}) begin n_fail++; $display("FAIL rnd_strobes cyc=%0d got=%b exp=%b", cyc, {m_read, m_write}, {e_rd, e_wr}); end
         if (e_wr || e_rd) begin
            n_checks++;
            if ({m_address, m_byteenable, m_writedata} !== {head[CMD_W-1 -: ADDR_W+BE_W], head[DATA_W-1:0]}) begin
               n_fail++; $display("FAIL rnd_fields cyc=%0d got=%h/%h/%h exp=%h", cyc, m_address, m_byteenable, m_writedata, head);
            end
         end
         pop  = (e_wr || e_rd) && !m_waitrequest;
         push = (s_read || s_write) && (exp_q.size() < CMD_DEPTH);
         resp = m_readdatavalid && (model_pend > 0);
         resp_data = m_readdata;
         tick();
         if (pop) void'(exp_q.pop_front());
         if (pop && e_rd) model_pend++;
         if (resp) model_pend--;
         if (push) exp_q.push_back({s_address, s_byteenable, s_write, s_writedata});
         n_checks++; if (s_readdatavalid !== resp) begin n_fail++; $display("FAIL rnd_rdv cyc=%0d got=%0b exp=%0b", cyc, s_readdatavalid, resp); end
         if (resp) begin
            n_checks++; if (s_readdata !== resp_data) begin n_fail++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, s_readdata, resp_data); end
         end
         n_checks++; if ({cmd_level, pending} !== {LVL_W'(exp_q.size()), PND_W'(model_pend)}) begin n_fail++; $display("FAIL rnd_levels cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, cmd_level, pending, exp_q.size(), model_pend); end
      end
      s_read = 1'b0; s_write = 1'b0; m_readdatavalid = 1'b0; m_waitrequest = 1'b0;
      n_checks++; if (err !== 2'b10) begin n_fail++; $display("FAIL rnd_err got=%b exp=10", err); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_backpressure();
      test_read_limit();
      test_simultaneous();
      test_errors();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
